// File: rtl/regfile_pkg.sv
// Shared types for the Y86 register-file writeback scheduler: widths, the
// "no register" ID, the buffered writeback entry and the scheduler states.
package regfile_pkg;

  localparam int REG_W  = 4;
  localparam int DATA_W = 64;
  localparam logic [REG_W-1:0] RNONE = 4'hF;

  typedef struct packed {
    logic [REG_W-1:0]  dstE;
    logic [DATA_W-1:0] valE;
    logic [REG_W-1:0]  dstM;
    logic [DATA_W-1:0] valM;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE_E = 2'd1,
    WRITE_M = 2'd2
  } sched_state_t;

  // The E half is dropped when it targets nothing or collides with M (popq %rsp).
  function automatic logic writesE(input wb_entry_t e);
    return (e.dstE != RNONE) && (e.dstE != e.dstM);
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_wb_fifo.sv
// In-order FIFO of writeback entries; exposes the head plus every slot in
// oldest-first order so the scheduler can search pending writes.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  wb_entry_t        pushEntry,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output wb_entry_t        head,
  output wb_entry_t        ordered [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= pushEntry;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ordered[i] = mem[rdPtr + PTR_W'(i)];
    end
  end

  assign head = mem[rdPtr];

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Serialises buffered E/M writebacks onto the single register-file write port.
// Optional macro RF_BYPASS_EN forwards pending writes to the decode read ports.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  in_dstE,
  input  logic [DATA_W-1:0] in_valE,
  input  logic [REG_W-1:0]  in_dstM,
  input  logic [DATA_W-1:0] in_valM,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  input  logic [REG_W-1:0]  srcA,
  input  logic [REG_W-1:0]  srcB,
  input  logic [DATA_W-1:0] rfA,
  input  logic [DATA_W-1:0] rfB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  sched_state_t     state;
  wb_entry_t        inEntry;
  wb_entry_t        head;
  wb_entry_t        ordered [DEPTH];
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             moreAfter;

  assign inEntry   = '{dstE: in_dstE, valE: in_valE, dstM: in_dstM, valM: in_valM};
  assign in_ready  = (count < DEPTH_C);
  assign push      = in_valid && in_ready;
  assign pop       = ((state == WRITE_E) && (head.dstM == RNONE)) || (state == WRITE_M);
  // Counting the same-edge push keeps back-to-back entries free of an IDLE bubble.
  assign moreAfter = (count > CNT_W'(1)) || push;
  assign busy      = (state != IDLE) || (count != '0);

  wb_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pushEntry (inEntry),
    .pop       (pop),
    .count     (count),
    .head      (head),
    .ordered   (ordered)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (count != '0) state <= WRITE_E;
        WRITE_E: begin
          if (head.dstM != RNONE) state <= WRITE_M;
          else                    state <= moreAfter ? WRITE_E : IDLE;
        end
        WRITE_M: state <= moreAfter ? WRITE_E : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = RNONE;
    rf_wdata = '0;
    case (state)
      WRITE_E: begin
        rf_we    = writesE(head);
        rf_waddr = head.dstE;
        rf_wdata = head.valE;
      end
      WRITE_M: begin
        rf_we    = 1'b1;
        rf_waddr = head.dstM;
        rf_wdata = head.valM;
      end
      default: ;
    endcase
  end

`ifdef RF_BYPASS_EN
  // Walk oldest to youngest so younger writes, and M within an entry, win.
  // The head's E half is already committed once the FSM sits in WRITE_M.
  always_comb begin
    valA = rfA;
    valB = rfB;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count) begin
        if (writesE(ordered[i]) && !((i == 0) && (state == WRITE_M))) begin
          if (ordered[i].dstE == srcA) valA = ordered[i].valE;
          if (ordered[i].dstE == srcB) valB = ordered[i].valE;
        end
        if (ordered[i].dstM != RNONE) begin
          if (ordered[i].dstM == srcA) valA = ordered[i].valM;
          if (ordered[i].dstM == srcB) valB = ordered[i].valM;
        end
      end
    end
  end
`else
  logic unusedBypass;

  assign valA = rfA;
  assign valB = rfB;

  always_comb begin
    unusedBypass = ^{srcA, srcB};
    for (int i = 0; i < DEPTH; i++) begin
      unusedBypass = unusedBypass ^ (^ordered[i]);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed timing scenarios plus a randomized
// run scored against a queue of expected register writes.
module tb_regfile_wb_scheduler;

  localparam logic [3:0] NONE = 4'hF;
  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_dstE = NONE;
  logic [63:0] in_valE = '0;
  logic [3:0]  in_dstM = NONE;
  logic [63:0] in_valM = '0;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        busy;
  logic [3:0]  srcA = NONE;
  logic [3:0]  srcB = NONE;
  logic [63:0] rfA = '0;
  logic [63:0] rfB = '0;
  logic [63:0] valA;
  logic [63:0] valB;

  typedef struct {
    logic [3:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t         expQ[$];
  logic [63:0] regs [16];
  int          checks = 0;
  int          errors = 0;

  regfile_wb_scheduler #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_dstE  (in_dstE),
    .in_valE  (in_valE),
    .in_dstM  (in_dstM),
    .in_valM  (in_valM),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .busy     (busy),
    .srcA     (srcA),
    .srcB     (srcB),
    .rfA      (rfA),
    .rfB      (rfB),
    .valA     (valA),
    .valB     (valB)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic offer(input logic [3:0] dE, input logic [63:0] vE,
                       input logic [3:0] dM, input logic [63:0] vM);
    in_valid = 1'b1;
    in_dstE  = dE;
    in_valE  = vE;
    in_dstM  = dM;
    in_valM  = vM;
  endtask

  task automatic doReset();
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b0;
    srcA     = NONE;
    srcB     = NONE;
    rfA      = '0;
    rfB      = '0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Forwarded value per the pending-write rules: youngest pending write wins.
  function automatic logic [63:0] fwd(input logic [3:0] src, input logic [63:0] rf);
    logic [63:0] v;
    v = rf;
    if (src == NONE) return rf;
`ifdef RF_BYPASS_EN
    foreach (expQ[i]) if (expQ[i].addr == src) v = expQ[i].data;
`endif
    return v;
  endfunction

  task automatic test_reset();
    #2;
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== NONE || rf_wdata !== 64'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: we=%b addr=%h data=%h busy=%b ready=%b, expected 0 f 0 0 1",
               rf_we, rf_waddr, rf_wdata, busy, in_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (rf_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: we=%b busy=%b ready=%b, expected 0 0 1", rf_we, busy, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    doReset();
    offer(4'd5, 64'h11, 4'd6, 64'h22);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 4'd6 || rf_wdata !== 64'h22) begin
      errors++;
      $display("FAIL midreset_writeM: we=%b addr=%h data=%h, expected 1 6 22", rf_we, rf_waddr, rf_wdata);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== NONE || rf_wdata !== 64'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: we=%b addr=%h data=%h busy=%b ready=%b, expected 0 f 0 0 1",
               rf_we, rf_waddr, rf_wdata, busy, in_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (rf_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL midreset_after%0d: we=%b busy=%b ready=%b, expected 0 0 1", i, rf_we, busy, in_ready);
      end
    end
  endtask

  task automatic test_single_e();
    doReset();
    offer(4'd2, 64'd65535, NONE, 64'd0);
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL singleE_queued: we=%b busy=%b, expected 0 1", rf_we, busy);
    end
    @(negedge clock);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 4'd2 || rf_wdata !== 64'd65535) begin
      errors++;
      $display("FAIL singleE_write: we=%b addr=%h data=%h, expected 1 2 ffff", rf_we, rf_waddr, rf_wdata);
    end
    @(negedge clock);
    checks++;
    if (rf_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL singleE_done: we=%b busy=%b, expected 0 0", rf_we, busy);
    end
  endtask

  task automatic test_e_then_m();
    doReset();
    offer(4'd0, 64'd255, 4'd1, 64'd127);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 4'd0 || rf_wdata !== 64'd255) begin
      errors++;
      $display("FAIL EM_writeE: we=%b addr=%h data=%h, expected 1 0 ff", rf_we, rf_waddr, rf_wdata);
    end
    @(negedge clock);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 4'd1 || rf_wdata !== 64'd127) begin
      errors++;
      $display("FAIL EM_writeM: we=%b addr=%h data=%h, expected 1 1 7f", rf_we, rf_waddr, rf_wdata);
    end
    @(negedge clock);
    checks++;
    if (rf_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL EM_done: we=%b busy=%b, expected 0 0", rf_we, busy);
    end
  endtask

  task automatic test_conflict();
    doReset();
    offer(4'd4, 64'd8, 4'd4, 64'h55);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (rf_we !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL conflict_noE: we=%b busy=%b, expected 0 1", rf_we, busy);
    end
    @(negedge clock);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 4'd4 || rf_wdata !== 64'h55) begin
      errors++;
      $display("FAIL conflict_writeM: we=%b addr=%h data=%h, expected 1 4 55", rf_we, rf_waddr, rf_wdata);
    end
    @(negedge clock);
    checks++;
    if (rf_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL conflict_done: we=%b busy=%b, expected 0 0", rf_we, busy);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    offer(4'd1, 64'd10, NONE, 64'd0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready0: ready=%b, expected 1", in_ready);
    end
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready1: ready=%b, expected 1", in_ready);
    end
    offer(4'd2, 64'd20, NONE, 64'd0);
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 4'd1 || rf_wdata !== 64'd10) begin
      errors++;
      $display("FAIL b2b_full: ready=%b we=%b addr=%h data=%h, expected 0 1 1 a",
               in_ready, rf_we, rf_waddr, rf_wdata);
    end
    offer(4'd3, 64'd30, NONE, 64'd0);
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 4'd2 || rf_wdata !== 64'd20) begin
      errors++;
      $display("FAIL b2b_second: ready=%b we=%b addr=%h data=%h, expected 1 1 2 14",
               in_ready, rf_we, rf_waddr, rf_wdata);
    end
    @(negedge clock);
    in_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 4'd3 || rf_wdata !== 64'd30) begin
      errors++;
      $display("FAIL b2b_third: we=%b addr=%h data=%h, expected 1 3 1e", rf_we, rf_waddr, rf_wdata);
    end
    @(negedge clock);
    checks++;
    if (rf_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: we=%b busy=%b, expected 0 0", rf_we, busy);
    end
  endtask

  task automatic test_bypass();
    logic [63:0] expA [5];
`ifdef RF_BYPASS_EN
    expA = '{64'hAA, 64'hBB, 64'hBB, 64'hBB, 64'h0};
`else
    expA = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
`endif
    doReset();
    srcA = 4'd3;
    rfA  = 64'd0;
    offer(4'd3, 64'hAA, NONE, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i == 0) offer(NONE, 64'd0, 4'd3, 64'hBB);
      else        in_valid = 1'b0;
      #1;
      checks++;
      if (valA !== expA[i]) begin
        errors++;
        $display("FAIL bypass_cycle%0d: valA=%h, expected %h", i, valA, expA[i]);
      end
    end
    srcA = NONE;
  endtask

  function automatic logic [3:0] pickReg();
    int r;
    r = $urandom_range(0, 5);
    return (r == 5) ? NONE : 4'(r);
  endfunction

  task automatic test_random();
    wr_t w;
    logic [63:0] eA;
    logic [63:0] eB;
    doReset();
    expQ.delete();
    for (int i = 0; i < 16; i++) regs[i] = {$urandom, $urandom};
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      eA = fwd(srcA, rfA);
      eB = fwd(srcB, rfB);
      checks++;
      if (valA !== eA || valB !== eB) begin
        errors++;
        $display("FAIL rand_fwd c%0d: valA=%h valB=%h, expected %h %h", c, valA, valB, eA, eB);
      end
      if (rf_we === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious c%0d: write addr=%h data=%h, expected no write", c, rf_waddr, rf_wdata);
        end else begin
          w = expQ.pop_front();
          if (rf_waddr !== w.addr || rf_wdata !== w.data) begin
            errors++;
            $display("FAIL rand_write c%0d: addr=%h data=%h, expected %h %h", c, rf_waddr, rf_wdata, w.addr, w.data);
          end
        end
        regs[rf_waddr] = rf_wdata;
      end
      in_valid = (c < 370) && ($urandom_range(0, 9) < 6);
      in_dstE  = pickReg();
      in_dstM  = pickReg();
      in_valE  = {$urandom, $urandom};
      in_valM  = {$urandom, $urandom};
      srcA     = pickReg();
      srcB     = pickReg();
      rfA      = regs[srcA];
      rfB      = regs[srcB];
      #1;
      if (in_valid && in_ready) begin
        if (in_dstE != NONE && in_dstE != in_dstM) expQ.push_back('{addr: in_dstE, data: in_valE});
        if (in_dstM != NONE) expQ.push_back('{addr: in_dstM, data: in_valM});
      end
    end
    checks++;
    if (expQ.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: pending=%0d busy=%b, expected 0 0", expQ.size(), busy);
    end
    in_valid = 1'b0;
    srcA = NONE;
    srcB = NONE;
  endtask

  initial begin
    test_reset();
    test_mid_reset();
    test_single_e();
    test_e_then_m();
    test_conflict();
    test_back_to_back();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
